// File: rtl/nsa_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
// State encoding and slice width used by the top and the nibble datapath.
package nsa_pkg;

  localparam int NIB = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder.
// One full adder per bit; carry ripples LSB to MSB.
module nibble_adder
  import nsa_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           ci,
  output logic [NIB-1:0] s,
  output logic           co
);

  logic [NIB:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIB; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign co = c[NIB];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams 4-bit slices, LSB first, through one
// nibble adder and assembles the sum with a start/busy/done handshake.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t state, state_d;

  logic [NIBBLES-1:0][NIB-1:0] a_r, b_r, sum_r;
  logic [IW-1:0]               idx;
  logic                        carry;
  logic                        accept, last;
  logic                        busy_d, done_d;
  logic [NIB-1:0]              ns;
  logic                        nco;

  nibble_adder u_add (
    .a  (a_r[idx]),
    .b  (b_r[idx]),
    .ci (carry),
    .s  (ns),
    .co (nco)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    last    = (idx == LAST);
    unique case (state)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          accept  = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      idx   <= '0;
      carry <= 1'b0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        a_r   <= a;
        b_r   <= b;
        carry <= cin;
        idx   <= '0;
        sum_r <= '0;
        cout  <= 1'b0;
        ovf   <= 1'b0;
      end else if (state == RUN) begin
        sum_r[idx] <= ns;
        carry      <= nco;
        if (last) begin
          cout <= nco;
          // sign of the result comes straight from the top nibble
          ovf  <= (a_r[NIBBLES-1][NIB-1] == b_r[NIBBLES-1][NIB-1])
               && (ns[NIB-1] != a_r[NIBBLES-1][NIB-1]);
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign sum = sum_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against
// a plain-arithmetic reference.
module tb_nibble_serial_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         ci = 1'b0;
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (opa),
    .b     (opb),
    .cin   (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       v;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return {v, t};
  endfunction

  // Present start; returns just after the accept edge.
  task automatic go(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic c);
    opa = x; opb = y; ci = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opa = W'($urandom); opb = W'($urandom); ci = 1'($urandom);
    chk("busy_acc", 32'(busy), 32'd1);
    chk("done_acc", 32'(done), 32'd0);
    chk("sum_clr", 32'(sum), 32'd0);
  endtask

  // Runs to the done cycle; inj>0 pulses a stray start after edge E+inj.
  task automatic finish(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input int inj);
    logic [W+1:0] e;
    e = model(x, y, c);
    for (int k = 1; k < N; k++) begin
      @(posedge clk); #1;
      chk("busy_run", 32'(busy), 32'd1);
      chk("done_run", 32'(done), 32'd0);
      if (k == inj) begin
        start = 1'b1;
        opa = W'($urandom); opb = W'($urandom); ci = 1'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(e[W-1:0]));
    chk("cout", 32'(cout), 32'(e[W]));
    chk("ovf", 32'(ovf), 32'(e[W+1]));
  endtask

  task automatic idle_after(input logic [W-1:0] s);
    @(posedge clk); #1;
    chk("done_fall", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum), 32'(s));
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y,
                    input logic c);
    logic [W+1:0] e;
    e = model(x, y, c);
    go(x, y, c);
    finish(x, y, c, 0);
    idle_after(e[W-1:0]);
  endtask

  initial begin
    logic [W-1:0] x, y, px, py;
    logic         c, pc;
    logic [W+1:0] e;

    rst = 1'b1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    start = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_done", 32'(done), 32'd0);

    op(16'h1234, 16'h4321, 1'b0);
    op(16'hFFFF, 16'h0001, 1'b0);
    op(16'h0000, 16'hFFFF, 1'b1);
    op(16'h7FFF, 16'h0001, 1'b0);
    op(16'h8000, 16'h8000, 1'b0);

    // stray start sampled at E+2 must be ignored
    go(16'h1111, 16'h2222, 1'b0);
    finish(16'h1111, 16'h2222, 1'b0, 1);
    repeat (N + 1) begin
      @(posedge clk); #1;
      chk("no_2nd_done", 32'(done), 32'd0);
      chk("no_2nd_busy", 32'(busy), 32'd0);
      chk("ign_sum", 32'(sum), 32'h3333);
    end

    // back-to-back: start held in DONE
    go(16'h2468, 16'h1357, 1'b1);
    finish(16'h2468, 16'h1357, 1'b1, 0);
    chk("b2b_prev", 32'(sum), 32'h37C0);
    go(16'h0F0F, 16'h0101, 1'b0);
    finish(16'h0F0F, 16'h0101, 1'b0, 0);
    chk("b2b_sum", 32'(sum), 32'h1010);
    idle_after(16'h1010);

    // reset at E+2 aborts
    go(16'hABCD, 16'h1234, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    repeat (N + 1) begin
      @(posedge clk); #1;
      chk("abort_nodone", 32'(done), 32'd0);
      chk("abort_nobusy", 32'(busy), 32'd0);
    end
    op(16'hABCD, 16'h1234, 1'b1);

    // random, with random back-to-back chaining
    px = W'($urandom); py = W'($urandom); pc = 1'($urandom);
    go(px, py, pc);
    for (int i = 0; i < 40; i++) begin
      finish(px, py, pc, (($urandom_range(0, 3) == 0) ? 2 : 0));
      e = model(px, py, pc);
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      if ($urandom_range(0, 1) == 0) idle_after(e[W-1:0]);
      go(x, y, c);
      px = x; py = y; pc = c;
    end
    finish(px, py, pc, 0);
    e = model(px, py, pc);
    idle_after(e[W-1:0]);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
